frame_parity_gen: RTL and testbench

//  Parametrised parity generator for the UART/serial datapath. Accumulates parity over a

---
 rtl/frame_parity_gen.sv | 191 +++++++++++++++++++
 tb/tb_frame_parity_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_parity_gen.sv
// -----------------------------------------------------------------------------
// frame_parity_gen
// Parity generator for the UART/serial datapath. It accumulates parity over a
// frame of 1..FRAME_MAX words and supports even, odd, mark and space modes.
// Words arrive on a valid/ready handshake. The result leaves on a valid/ack
// handshake towards the serializer.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   P_DATA     in   input word (DATA_WIDTH bits)
//   Data_Valid in   P_DATA valid
//   in_ready   out  block can accept a word
//   busy       in   downstream serializer busy; stalls word acceptance
//   PAR_EN     in   enable; low aborts a frame in progress
//   PAR_MODE   in   00 even, 01 odd, 10 mark, 11 space
//   FRAME_LEN  in   words per frame (0 -> 1, >FRAME_MAX -> FRAME_MAX)
//   par_bit    out  registered frame parity
//   par_valid  out  par_bit valid, held until par_ack
//   par_ack    in   consumer takes the result
//
// Optional macro PAR_CHECK_EN adds a receive-side check:
//   RX_PAR     in   received parity bit
//   par_err    out  one-cycle pulse on par_ack when RX_PAR != par_bit
// -----------------------------------------------------------------------------
module frame_parity_gen #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FRAME_MAX  = 16,
   parameter int unsigned LEN_W      = 5
) (
   input  logic                  CLK,
   input  logic                  RST,
`ifdef PAR_CHECK_EN
   input  logic                  RX_PAR,
   output logic                  par_err,
`else
   // Receive-side check ports are absent in this build.
`endif
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   output logic                  in_ready,
   input  logic                  busy,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_MODE,
   input  logic [LEN_W-1:0]      FRAME_LEN,
   output logic                  par_bit,
   output logic                  par_valid,
   input  logic                  par_ack
);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e             r_state,     w_state_nxt;
   logic [LEN_W-1:0]   r_cnt,       w_cnt_nxt;
   logic [LEN_W-1:0]   r_len,       w_len_nxt;
   logic [1:0]         r_mode,      w_mode_nxt;
   logic               r_xr,        w_xr_nxt;
   logic               r_par_bit,   w_par_bit_nxt;
   logic               r_par_valid, w_par_valid_nxt;

   logic               w_acc;
   logic               w_word_par;
   logic               w_xr_acc;
   logic [LEN_W-1:0]   w_len_eff;
   logic [LEN_W-1:0]   w_cnt_inc;

   // Final parity bit for a given mode and accumulated XOR.
   function automatic logic f_par(input logic [1:0] mode, input logic xr);
      logic res;
      case (mode)
         2'b00:   res = xr;
         2'b01:   res = ~xr;
         2'b10:   res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   assign in_ready   = PAR_EN & ~busy & ((r_state == StIdle) | (r_state == StAccum));
   assign w_acc      = Data_Valid & in_ready;
   assign w_word_par = ^P_DATA;
   assign w_xr_acc   = r_xr ^ w_word_par;
   assign w_cnt_inc  = r_cnt + LEN_W'(1);

   always_comb begin
      if (FRAME_LEN == '0) begin
         w_len_eff = LEN_W'(1);
      end else if (FRAME_LEN > LEN_W'(FRAME_MAX)) begin
         w_len_eff = LEN_W'(FRAME_MAX);
      end else begin
         w_len_eff = FRAME_LEN;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_len_nxt       = r_len;
      w_mode_nxt      = r_mode;
      w_xr_nxt        = r_xr;
      w_par_bit_nxt   = r_par_bit;
      w_par_valid_nxt = r_par_valid;
      unique case (r_state)
         StIdle: begin
            if (w_acc) begin
               // Mode and length are frozen here for the whole frame.
               w_mode_nxt = PAR_MODE;
               w_len_nxt  = w_len_eff;
               w_xr_nxt   = w_word_par;
               w_cnt_nxt  = LEN_W'(1);
               if (w_len_eff == LEN_W'(1)) begin
                  w_state_nxt     = StDone;
                  w_par_bit_nxt   = f_par(PAR_MODE, w_word_par);
                  w_par_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = StAccum;
               end
            end
         end
         StAccum: begin
            if (!PAR_EN) begin
               // Abort: discard the partial frame, keep the last result.
               w_state_nxt = StIdle;
               w_cnt_nxt   = '0;
               w_xr_nxt    = 1'b0;
            end else if (w_acc) begin
               w_xr_nxt  = w_xr_acc;
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == r_len) begin
                  w_state_nxt     = StDone;
                  w_par_bit_nxt   = f_par(r_mode, w_xr_acc);
                  w_par_valid_nxt = 1'b1;
               end
            end
         end
         StDone: begin
            if (par_ack) begin
               w_state_nxt     = StIdle;
               w_par_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_len       <= '0;
         r_mode      <= 2'b00;
         r_xr        <= 1'b0;
         r_par_bit   <= 1'b0;
         r_par_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_len       <= w_len_nxt;
         r_mode      <= w_mode_nxt;
         r_xr        <= w_xr_nxt;
         r_par_bit   <= w_par_bit_nxt;
         r_par_valid <= w_par_valid_nxt;
      end
   end

   assign par_bit   = r_par_bit;
   assign par_valid = r_par_valid;

`ifdef PAR_CHECK_EN
   logic r_par_err;
   logic w_par_err_nxt;

   // Compared against the held result on the ack cycle; self-clears next cycle.
   assign w_par_err_nxt = (r_state == StDone) & par_ack & (RX_PAR != r_par_bit);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_par_err <= 1'b0;
      end else begin
         r_par_err <= w_par_err_nxt;
      end
   end

   assign par_err = r_par_err;
`else
   // No receive-side check logic in this build.
`endif

endmodule

// File: tb/tb_frame_parity_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_parity_gen
// Self-checking bench for frame_parity_gen. Directed scenarios followed by
// randomized frames. Expected parity comes from a ones-count reference model.
// -----------------------------------------------------------------------------
module tb_frame_parity_gen;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] P_DATA = '0;
   logic       Data_Valid = 1'b0;
   logic       in_ready;
   logic       busy = 1'b0;
   logic       PAR_EN = 1'b1;
   logic [1:0] PAR_MODE = 2'b00;
   logic [4:0] FRAME_LEN = 5'd1;
   logic       par_bit;
   logic       par_valid;
   logic       par_ack = 1'b0;
`ifdef PAR_CHECK_EN
   logic       RX_PAR = 1'b0;
   logic       par_err;
`endif

   int         errors = 0;
   int         checks = 0;
   logic [7:0] words [0:31];
   logic       last_par;

   frame_parity_gen #(
      .DATA_WIDTH(8),
      .FRAME_MAX (16),
      .LEN_W     (5)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
`ifdef PAR_CHECK_EN
      .RX_PAR    (RX_PAR),
      .par_err   (par_err),
`endif
      .P_DATA    (P_DATA),
      .Data_Valid(Data_Valid),
      .in_ready  (in_ready),
      .busy      (busy),
      .PAR_EN    (PAR_EN),
      .PAR_MODE  (PAR_MODE),
      .FRAME_LEN (FRAME_LEN),
      .par_bit   (par_bit),
      .par_valid (par_valid),
      .par_ack   (par_ack)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_len(input logic [4:0] fl);
      if (fl == 5'd0) return 1;
      if (fl > 5'd16) return 16;
      return int'(fl);
   endfunction

   // Parity from the total number of set bits in the frame.
   function automatic logic ref_par(input logic [1:0] mode, input int len);
      int ones = 0;
      for (int i = 0; i < len; i++) ones += $countones(words[i]);
      case (mode)
         2'b00:   return logic'(ones % 2);
         2'b01:   return logic'(1 - (ones % 2));
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Present a word and hold it until accepted (bounded wait).
   task automatic push(input logic [7:0] d);
      int n = 0;
      P_DATA     = d;
      Data_Valid = 1'b1;
      @(negedge CLK);
      while (!in_ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check("push_ready", {7'd0, in_ready}, 8'd1);
      step();
      Data_Valid = 1'b0;
   endtask

   // Hold a word with busy high; nothing may be accepted.
   task automatic stall(input logic [7:0] d, input int cycles);
      P_DATA     = d;
      Data_Valid = 1'b1;
      busy       = 1'b1;
      for (int k = 0; k < cycles; k++) begin
         @(negedge CLK);
         check("stall_ready", {7'd0, in_ready}, 8'd0);
         check("stall_valid", {7'd0, par_valid}, 8'd0);
      end
      step();
      busy = 1'b0;
   endtask

   task automatic ack_check(input logic exp_bit, input logic rx, input int hold);
      check("res_valid", {7'd0, par_valid}, 8'd1);
      check("res_bit", {7'd0, par_bit}, {7'd0, exp_bit});
      check("done_ready", {7'd0, in_ready}, 8'd0);
      for (int k = 0; k < hold; k++) begin
         step();
         check("hold_valid", {7'd0, par_valid}, 8'd1);
      end
`ifdef PAR_CHECK_EN
      RX_PAR = rx;
`endif
      par_ack = 1'b1;
      step();
      par_ack = 1'b0;
      check("ack_valid", {7'd0, par_valid}, 8'd0);
      check("ack_bit_hold", {7'd0, par_bit}, {7'd0, exp_bit});
      check("ack_ready", {7'd0, in_ready}, {7'd0, PAR_EN & ~busy});
`ifdef PAR_CHECK_EN
      check("par_err", {7'd0, par_err}, {7'd0, rx != exp_bit});
      step();
      check("par_err_clr", {7'd0, par_err}, 8'd0);
`else
      if (rx) step();
`endif
      last_par = exp_bit;
   endtask

   // One frame from words[]; optional random stalls and mid-frame config changes.
   task automatic run_frame(input logic [1:0] mode, input logic [4:0] flen,
                            input bit rnd, input logic rx);
      int  len  = eff_len(flen);
      logic exp = ref_par(mode, len);
      PAR_MODE  = mode;
      FRAME_LEN = flen;
      for (int i = 0; i < len; i++) begin
         if (rnd && $urandom_range(0, 2) == 0) stall(words[i], int'($urandom_range(1, 4)));
         push(words[i]);
         if (i == 0) begin
            PAR_MODE  = 2'($urandom);
            FRAME_LEN = 5'($urandom);
         end
         if (i < len - 1) check("mid_valid", {7'd0, par_valid}, 8'd0);
      end
      ack_check(exp, rx, rnd ? int'($urandom_range(0, 3)) : 0);
   endtask

   initial begin
      last_par = 1'b0;
      #1;
      check("rst_valid", {7'd0, par_valid}, 8'd0);
      check("rst_bit", {7'd0, par_bit}, 8'd0);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      step();
      check("idle_ready", {7'd0, in_ready}, 8'd1);

      // par_ack outside DONE is ignored.
      par_ack = 1'b1;
      repeat (2) step();
      check("ack_idle_valid", {7'd0, par_valid}, 8'd0);
      check("ack_idle_ready", {7'd0, in_ready}, 8'd1);
      par_ack = 1'b0;

      // 1: even, single word 0xA5.
      words[0] = 8'hA5;
      run_frame(2'b00, 5'd1, 1'b0, 1'b0);

      // 2: odd, three words; then PAR_EN low in DONE keeps the result.
      words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h07;
      PAR_MODE = 2'b01; FRAME_LEN = 5'd3;
      push(words[0]); push(words[1]); push(words[2]);
      PAR_EN = 1'b0;
      repeat (3) begin
         step();
         check("en_low_done_valid", {7'd0, par_valid}, 8'd1);
         check("en_low_done_ready", {7'd0, in_ready}, 8'd0);
      end
      PAR_EN = 1'b1;
      ack_check(1'b1, 1'b1, 0);

      // 3: mark then space, then FRAME_LEN=0 acting as one word.
      words[0] = 8'h3C; words[1] = 8'h81;
      run_frame(2'b10, 5'd2, 1'b0, 1'b1);
      run_frame(2'b11, 5'd2, 1'b0, 1'b0);
      words[0] = 8'h07;
      run_frame(2'b00, 5'd0, 1'b0, 1'b1);

      // 4: even, four words with a 5-cycle busy stall after word 2.
      words[0] = 8'h01; words[1] = 8'hFF; words[2] = 8'h10; words[3] = 8'h0E;
      PAR_MODE = 2'b00; FRAME_LEN = 5'd4;
      push(words[0]); push(words[1]);
      stall(words[2], 5);
      push(words[2]);
      check("stall_mid_valid", {7'd0, par_valid}, 8'd0);
      push(words[3]);
      ack_check(ref_par(2'b00, 4), 1'b0, 0);

      // 5: abort after word 2, then a fresh single-word frame.
      words[0] = 8'h55; words[1] = 8'h01;
      PAR_MODE = 2'b01; FRAME_LEN = 5'd4;
      push(words[0]); push(words[1]);
      PAR_EN = 1'b0;
      repeat (3) begin
         step();
         check("abort_valid", {7'd0, par_valid}, 8'd0);
         check("abort_bit_hold", {7'd0, par_bit}, {7'd0, last_par});
      end
      PAR_EN = 1'b1;
      words[0] = 8'h0F;
      run_frame(2'b00, 5'd1, 1'b0, 1'b0);
      words[0] = 8'h01; words[1] = 8'h02;
      run_frame(2'b00, 5'd2, 1'b0, 1'b0);

      // 6: reset in the middle of a frame, after a result of 1.
      words[0] = 8'h01;
      run_frame(2'b00, 5'd1, 1'b0, 1'b1);
      PAR_MODE = 2'b00; FRAME_LEN = 5'd4;
      push(8'h01);
      RST = 1'b0;
      #1;
      check("rst_mid_bit", {7'd0, par_bit}, 8'd0);
      check("rst_mid_valid", {7'd0, par_valid}, 8'd0);
      step();
      RST = 1'b1;
      step();
      check("rst_mid_ready", {7'd0, in_ready}, 8'd1);
      words[0] = 8'h03;
      run_frame(2'b00, 5'd1, 1'b0, 1'b1);

      // Clamp: FRAME_LEN above FRAME_MAX runs exactly 16 words.
      for (int i = 0; i < 16; i++) words[i] = 8'(i * 7 + 1);
      run_frame(2'b01, 5'd25, 1'b0, 1'b0);

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
         run_frame(2'($urandom), 5'($urandom_range(0, 20)), 1'b1, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
